// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory behind a multi-cycle IDLE/ACCESS/DONE FSM.
// BUSYWAIT stalls the CPU from the issue cycle until the access commits.
module data_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] READDATA,
    output logic                  BUSYWAIT
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  req;
    logic                  last;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // READ and WRITE together is illegal and counts as no request.
    assign req  = READ ^ WRITE;
    assign last = (cnt == LAST_CNT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = ACCESS;
            ACCESS:  if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSYWAIT = 1'b0;
        case (state)
            IDLE:    BUSYWAIT = req;
            ACCESS:  BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
        endcase
    end

    // Request capture, latency counter and the committing memory access.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt      <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            READDATA <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= ADDRESS;
                        wdata_q <= WRITEDATA;
                        write_q <= WRITE;
                        cnt     <= 4'd0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (last) begin
                        if (write_q) begin
                            mem[addr_q] <= wdata_q;
                        end else begin
                            READDATA <= mem[addr_q];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
